// File: rtl/c7bicu.sv
// c7bicu: instruction-fetch bus interface with an optional single-line buffer.
// One fetch is in flight at a time. A line-buffer hit answers one cycle after
// the ack. A miss issues an aligned 8-byte bus read and returns the bus data.
module c7bicu #(
  parameter bit LBUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:0] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2,
  output logic        icu_biu_req,
  output logic [31:0] icu_biu_addr,
  input  logic        biu_icu_ack,
  input  logic        biu_icu_rvalid,
  input  logic [63:0] biu_icu_rdata,
  input  logic        icu_inv
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HIT      = 3'd1,
    BUS_REQ  = 3'd2,
    BUS_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Line buffer: a single 8-byte line, tagged by address bits [31:3].
  logic        lbuf_vld_reg;
  logic [28:0] lbuf_tag_reg;
  logic [63:0] lbuf_data_reg;

  // Aligned address of the outstanding miss and the data for the next response.
  logic [31:0] req_addr_reg;
  logic [63:0] resp_data_reg;

  logic        hit;
  logic        accept;
  logic        capture;

  // Byte-offset bits of the fetch address play no part in an 8-byte fetch.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^ifu_icu_addr_ic1[2:0];

  // Hit detection, request acceptance and bus-data capture qualifiers.
  always_comb begin
    hit     = LBUF_EN & lbuf_vld_reg & ~icu_inv
              & (lbuf_tag_reg == ifu_icu_addr_ic1[31:3]);
    // Reset gating keeps the ack low while reset is held, even though the
    // state register already reads IDLE.
    accept  = ifu_icu_req_ic1 & (state_reg == IDLE) & ~reset;
    // Bus data is taken either together with the bus ack or later in BUS_WAIT;
    // rvalid in any other state is a stale beat and is dropped.
    capture = ((state_reg == BUS_REQ) & biu_icu_ack & biu_icu_rvalid)
              | ((state_reg == BUS_WAIT) & biu_icu_rvalid);
  end

  // Next-state and output decode.
  always_comb begin
    state_next             = state_reg;
    icu_ifu_ack_ic1        = accept;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_ifu_data_ic2       = 64'h0;
    icu_biu_req            = 1'b0;
    icu_biu_addr           = 32'h0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = hit ? HIT : BUS_REQ;
        end
      end
      HIT: begin
        icu_ifu_data_valid_ic2 = 1'b1;
        icu_ifu_data_ic2       = resp_data_reg;
        state_next             = IDLE;
      end
      BUS_REQ: begin
        icu_biu_req  = 1'b1;
        icu_biu_addr = req_addr_reg;
        if (biu_icu_ack) begin
          state_next = biu_icu_rvalid ? RESP : BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (biu_icu_rvalid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        icu_ifu_data_valid_ic2 = 1'b1;
        icu_ifu_data_ic2       = resp_data_reg;
        state_next             = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the aligned miss address when a missing request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_reg <= 32'h0;
    end else if (accept && !hit) begin
      req_addr_reg <= {ifu_icu_addr_ic1[31:3], 3'b000};
    end
  end

  // Response data: a copy of the line buffer on a hit, the bus beat on a miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data_reg <= 64'h0;
    end else if (accept && hit) begin
      resp_data_reg <= lbuf_data_reg;
    end else if (capture) begin
      resp_data_reg <= biu_icu_rdata;
    end
  end

  // Line buffer fill and invalidate; an invalidate in the fill cycle wins,
  // so the filled line is left invalid but the data is still returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      lbuf_vld_reg  <= 1'b0;
      lbuf_tag_reg  <= 29'h0;
      lbuf_data_reg <= 64'h0;
    end else if (capture) begin
      lbuf_vld_reg  <= LBUF_EN & ~icu_inv;
      lbuf_tag_reg  <= req_addr_reg[31:3];
      lbuf_data_reg <= biu_icu_rdata;
    end else if (icu_inv) begin
      lbuf_vld_reg  <= 1'b0;
    end
  end

  // Response pulses are always single-cycle.
  a_single_pulse: assert property (@(posedge clk) disable iff (reset)
    icu_ifu_data_valid_ic2 |=> !icu_ifu_data_valid_ic2);

  // The bus address is quiet whenever no bus request is presented.
  a_quiet_bus_addr: assert property (@(posedge clk) disable iff (reset)
    !icu_biu_req |-> (icu_biu_addr == 32'h0));

  // A fetch can only be acked while no bus read is being requested.
  a_ack_not_busy: assert property (@(posedge clk) disable iff (reset)
    icu_ifu_ack_ic1 |-> !icu_biu_req);

endmodule
